// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int unsigned BCD_MAX_8 = 99_999_999;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned HEX_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Widen a BCD digit to a hex line; an overflowed value saturates to 9.
    function automatic logic [HEX_W-1:0] digit_to_hex(
        input logic [DIGIT_W-1:0] digit,
        input logic               force_nine
    );
        if (force_nine) begin
            return HEX_W'(9);
        end
        return {{(HEX_W-DIGIT_W){1'b0}}, digit};
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted_c
);

    always_comb begin
        adjusted_c = digit;
        if (digit >= DIGIT_W'(5)) begin
            adjusted_c = DIGIT_W'(digit + DIGIT_W'(3));
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with a start/busy/done handshake and digits held between conversions.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W      = 27,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf,
    output logic [HEX_W-1:0] o_hex0,
    output logic [HEX_W-1:0] o_hex1,
    output logic [HEX_W-1:0] o_hex2,
    output logic [HEX_W-1:0] o_hex3,
    output logic [HEX_W-1:0] o_hex4,
    output logic [HEX_W-1:0] o_hex5,
    output logic [HEX_W-1:0] o_hex6,
    output logic [HEX_W-1:0] o_hex7
);

    localparam int unsigned SCR_W = DIGIT_W * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   adj_c;
    logic [SCR_W-1:0]   scratch_next_c;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic [HEX_W-1:0]   hex_q [NUM_DIGITS];

    // Per-digit add-3 correction ahead of each shift.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit      (scratch[g*DIGIT_W +: DIGIT_W]),
            .adjusted_c (adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    // The MSB of the binary shift register enters the ones digit.
    assign scratch_next_c = {adj_c[SCR_W-2:0], shreg[BIN_W-1]};

    // FSM, counter, scratch and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_ovf    <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                hex_q[d] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        shreg    <= i_bin;
                        scratch  <= '0;
                        cnt      <= CNT_W'(BIN_W);
                        ovf_pend <= (32'(i_bin) > BCD_MAX_8);
                        o_busy   <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    scratch <= scratch_next_c;
                    shreg   <= {shreg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    // Last shift: publish the final digits on the same edge.
                    if (cnt == CNT_W'(1)) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                        o_ovf  <= ovf_pend;
                        for (int d = 0; d < NUM_DIGITS; d++) begin
                            hex_q[d] <= digit_to_hex(
                                scratch_next_c[d*DIGIT_W +: DIGIT_W], ovf_pend);
                        end
                    end
                end

                ST_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_hex0 = hex_q[0];
    assign o_hex1 = hex_q[1];
    assign o_hex2 = hex_q[2];
    assign o_hex3 = hex_q[3];
    assign o_hex4 = hex_q[4];
    assign o_hex5 = hex_q[5];
    assign o_hex6 = hex_q[6];
    assign o_hex7 = hex_q[7];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [26:0] bin;
    logic        busy, done, ovf;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int          lat, busy_cnt, n_done, prev, nb;
    logic [31:0] dig_done, dig_end;
    logic        ovf_done, hi_done;

    bin2bcd_seq dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_bin   (bin),
        .o_busy  (busy),
        .o_done  (done),
        .o_ovf   (ovf),
        .o_hex0  (hex0),
        .o_hex1  (hex1),
        .o_hex2  (hex2),
        .o_hex3  (hex3),
        .o_hex4  (hex4),
        .o_hex5  (hex5),
        .o_hex6  (hex6),
        .o_hex7  (hex7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cur_dig();
        return {hex7[3:0], hex6[3:0], hex5[3:0], hex4[3:0],
                hex3[3:0], hex2[3:0], hex1[3:0], hex0[3:0]};
    endfunction

    function automatic logic cur_hi();
        return |{hex7[6:4], hex6[6:4], hex5[6:4], hex4[6:4],
                 hex3[6:4], hex2[6:4], hex1[6:4], hex0[6:4]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One accepted start of v, then 70 observed cycles; optionally re-pulse start at poke_at.
    task automatic run_conv(input logic [26:0] v, input int poke_at, input logic [26:0] poke_val,
                            output int o_lat, output int o_busy_cnt, output int o_n_done,
                            output logic [31:0] o_dig_done, output logic o_ovf_done,
                            output logic o_hi_done, output logic [31:0] o_dig_end);
        o_lat = 0; o_busy_cnt = 0; o_n_done = 0;
        o_dig_done = '0; o_ovf_done = 1'b0; o_hi_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            start = (k == poke_at);
            if (k == poke_at) bin = poke_val;
            if (busy) o_busy_cnt++;
            if (done) begin
                o_n_done++;
                if (o_lat == 0) begin
                    o_lat      = k;
                    o_dig_done = cur_dig();
                    o_ovf_done = ovf;
                    o_hi_done  = cur_hi();
                end
            end
        end
        start     = 1'b0;
        o_dig_end = cur_dig();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        check("rst_hex",  cur_dig(), 32'h0);
        rst = 1'b0;

        // Zero: latency and busy width.
        run_conv(27'd0, 0, 27'd0, lat, busy_cnt, n_done, dig_done, ovf_done, hi_done, dig_end);
        check("zero_latency", 32'(lat), 32'd28);
        check("zero_busy",    32'(busy_cnt), 32'd28);
        check("zero_ndone",   32'(n_done), 32'd1);
        check("zero_hex",     dig_done, 32'h0);
        check("zero_ovf",     32'(ovf_done), 32'd0);

        // Mixed digits, held across idle cycles.
        run_conv(27'd12_345_678, 0, 27'd0, lat, busy_cnt, n_done, dig_done, ovf_done, hi_done, dig_end);
        check("mix_hex",   dig_done, 32'h1234_5678);
        check("mix_ovf",   32'(ovf_done), 32'd0);
        check("mix_upper", 32'(hi_done), 32'd0);
        check("mix_hold",  dig_end, 32'h1234_5678);
        check("mix_done_low", 32'(done), 32'd0);

        // Largest in-range value, then the first overflowing one.
        run_conv(27'd99_999_999, 0, 27'd0, lat, busy_cnt, n_done, dig_done, ovf_done, hi_done, dig_end);
        check("max_hex", dig_done, 32'h9999_9999);
        check("max_ovf", 32'(ovf_done), 32'd0);
        run_conv(27'd100_000_000, 0, 27'd0, lat, busy_cnt, n_done, dig_done, ovf_done, hi_done, dig_end);
        check("ovf_hex",  dig_done, 32'h9999_9999);
        check("ovf_ovf",  32'(ovf_done), 32'd1);
        check("ovf_hold", 32'(ovf), 32'd1);

        // Start pulse during SHIFT is ignored.
        run_conv(27'd5, 9, 27'd77, lat, busy_cnt, n_done, dig_done, ovf_done, hi_done, dig_end);
        check("ign_ndone",   32'(n_done), 32'd1);
        check("ign_latency", 32'(lat), 32'd28);
        check("ign_hex",     dig_done, 32'h0000_0005);
        check("ign_ovf_clr", 32'(ovf_done), 32'd0);
        run_conv(27'd77, 0, 27'd0, lat, busy_cnt, n_done, dig_done, ovf_done, hi_done, dig_end);
        check("s77_hex", dig_done, 32'h0000_0077);

        // Reset mid-conversion aborts it.
        run_conv(27'd42, 0, 27'd0, lat, busy_cnt, n_done, dig_done, ovf_done, hi_done, dig_end);
        check("s42_hex", dig_done, 32'h0000_0042);
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd9_000_001;
        @(posedge clk);
        nb = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 14) rst = 1'b1;
            if (k == 15) begin
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_ovf",  32'(ovf),  32'd0);
                check("abort_hex",  cur_dig(), 32'h0);
                rst = 1'b0;
            end
            if (done) nb++;
        end
        check("abort_ndone", 32'(nb), 32'd0);
        run_conv(27'd9_000_001, 0, 27'd0, lat, busy_cnt, n_done, dig_done, ovf_done, hi_done, dig_end);
        check("after_abort_hex", dig_done, 32'h0900_0001);
        check("after_abort_lat", 32'(lat), 32'd28);

        // Start held high: one conversion every 29 cycles.
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd1;
        prev  = -1;
        nb    = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin
                nb++;
                check("b2b_hex", cur_dig(), 32'h0000_0001);
                if (prev >= 0) check("b2b_period", 32'(k - prev), 32'd29);
                prev = k;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(nb), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
